freeblk_client: RTL and testbench
=================================

Name: freeblk_client

Overview:
Consumer end of the free-block handshake. It prefetches free block IDs from the free-bit manager (wrblkrdy/wrblkget/wrblkid) into a small cache and serves them to a write engine on request. It also queues block IDs released by the read side and issues them to the manager as single-cycle rdblkfree/rdblkid pulses. Releases are held off until the manager's bitmap initialisation window has elapsed.

Parameters:
ADDBLK, 11, block ID width
ADDCAC, 2, log2 prefetch cache depth (depth 4)
ADDREL, 3, log2 release queue depth (depth 8)
INITDLY, 70, cycles after active rises before releases may be issued (manager init length plus margin)

Ports:
clk  in  1  clock
rst  in  1  reset
active  in  1  block enable; low flushes all state
wrblkrdy  in  1  manager has a free block
wrblkid  in  ADDBLK  free block ID, valid while wrblkrdy
wrblkget  out  1  take the block on wrblkid this cycle
rdblkfree  out  1  release pulse to manager
rdblkid  out  ADDBLK  released block ID, valid with rdblkfree
eng_req  in  1  engine requests one block (pulse)
eng_ack  out  1  block granted (pulse)
eng_blkid  out  ADDBLK  granted ID, valid with eng_ack
eng_busy  out  1  request pending, not yet acked
rel_vld  in  1  read side releases a block
rel_id  in  ADDBLK  released ID
rel_full  out  1  release queue full
cache_len  out  ADDCAC+1  blocks in prefetch cache
rel_drop  out  1  alarm: release lost on a full queue
eng_miss  out  1  alarm: eng_req arrived with the cache empty
dup_err  out  1  alarm: duplicate or foreign release (optional feature)

Behaviour:
- Reset is rst: synchronous, active-high. Clock is clk. All outputs reset to 0 and both FIFOs are emptied.
- Control FSM states are IDLE, INIT and RUN.
  - IDLE: entered whenever active is low. Cache and release queue are flushed, the init counter is cleared, and no wrblkget, rdblkfree or eng_ack is issued.
  - INIT: entered when active is seen high. The counter counts up to INITDLY-1, then the FSM moves to RUN. Prefetch is allowed in INIT. Releases are accepted into the queue but are not issued.
  - RUN: full operation.
  - active falling in any state returns the FSM to IDLE on the next cycle. A pending engine request is dropped and eng_busy clears.
- Prefetch:
  - wrblkget = wrblkrdy & (state != IDLE) & (cache_len < 2^ADDCAC). This is combinational and takes the same cycle as wrblkrdy.
  - wrblkid is written to the cache in that cycle, and cache_len updates on the next cycle.
  - A cache write and a cache read in the same cycle leave cache_len unchanged.
- Engine grant:
  - eng_req is sampled in cycle N. If the cache is non-empty in cycle N, eng_ack and eng_blkid (the cache head) are registered and appear in cycle N+1.
  - If the cache is empty in cycle N, eng_miss pulses in N+1 and eng_busy is set. eng_ack follows one cycle after the first cycle the cache is non-empty.
  - eng_req while eng_busy is high is ignored.
  - The engine waits for eng_ack before its next request. Grants are in FIFO order of arrival from the manager.
- Release path:
  - rel_vld with the queue not full writes rel_id to the queue.
  - rel_vld with the queue full drops the ID; rel_drop pulses the next cycle.
  - rel_full = queue length == 2^ADDREL (registered).
  - In RUN with the queue non-empty, the head is popped. rdblkfree=1 and rdblkid=head are registered and appear one cycle after the pop. At most one release is issued per cycle, back-to-back allowed.
  - A simultaneous push and pop on a full queue is accepted with no drop.
- Wrap-around: both FIFO pointers wrap modulo their depth. The init counter saturates at INITDLY-1.

Optional Feature:
Macro FREEBLK_DUPCHK_EN.
- With the macro: a 2^ADDBLK-bit ownership map is kept.
  - A bit sets when its ID is taken via wrblkget.
  - A bit clears when its ID is written to the release queue.
  - A rel_vld whose ID bit is already 0 is not queued, and dup_err pulses the next cycle.
  - The map is cleared in IDLE.
- Without the macro: dup_err is tied 0, every release is queued, and no map is instantiated.

Test Plan:
- Reset then active=1 with wrblkrdy=1 continuously (IDs 0x010..0x013) -> wrblkget high for exactly 4 cycles; cache_len=4 and holds; wrblkget=0 thereafter.
- Cache holding 0x010..0x013, eng_req pulse at cycle 100 -> eng_ack and eng_blkid=0x010 at cycle 101; cache_len refills to 4.
- wrblkrdy=0 and cache empty, eng_req at cycle 50, wrblkrdy=1 with ID 0x2A5 at cycle 60 -> eng_miss at 51; eng_busy high 51..61; eng_ack with ID 0x2A5 at 62.
- rel_vld with ID 0x005 at cycle 5 after active rises -> no rdblkfree before cycle INITDLY (70); rdblkfree with rdblkid=0x005 afterwards.
- Nine back-to-back rel_vld while in INIT -> rel_full=1 after the 8th; the 9th is dropped with a rel_drop pulse; in RUN exactly 8 rdblkfree pulses follow in order.
- With FREEBLK_DUPCHK_EN: take 0x033, release it twice -> one rdblkfree; dup_err pulses once on the second release. active drop mid-queue -> queue empty, no further rdblkfree.

Source files
------------

// File: rtl/freeblk_client_if.sv
// freeblk_client_if: manager, engine and release-side signals of freeblk_client; slave = client, master = environment
interface freeblk_client_if #(
  parameter int ADDBLK = 11,
  parameter int ADDCAC = 2
);
  logic              active;
  logic              wrblkrdy;
  logic [ADDBLK-1:0] wrblkid;
  logic              wrblkget;
  logic              rdblkfree;
  logic [ADDBLK-1:0] rdblkid;
  logic              eng_req;
  logic              eng_ack;
  logic [ADDBLK-1:0] eng_blkid;
  logic              eng_busy;
  logic              rel_vld;
  logic [ADDBLK-1:0] rel_id;
  logic              rel_full;
  logic [ADDCAC:0]   cache_len;
  logic              rel_drop;
  logic              eng_miss;
  logic              dup_err;
  modport slave (
    input  active, wrblkrdy, wrblkid, eng_req, rel_vld, rel_id,
    output wrblkget, rdblkfree, rdblkid, eng_ack, eng_blkid, eng_busy,
           rel_full, cache_len, rel_drop, eng_miss, dup_err
  );
  modport master (
    output active, wrblkrdy, wrblkid, eng_req, rel_vld, rel_id,
    input  wrblkget, rdblkfree, rdblkid, eng_ack, eng_blkid, eng_busy,
           rel_full, cache_len, rel_drop, eng_miss, dup_err
  );
endinterface

// File: rtl/freeblk_client.sv
// freeblk_client: prefetches free block IDs into a cache for the engine and queues released IDs back to the manager; ports clk, rst, bus (freeblk_client_if.slave); FREEBLK_DUPCHK_EN adds an ownership map driving dup_err
module freeblk_client #(
  parameter int ADDBLK  = 11,
  parameter int ADDCAC  = 2,
  parameter int ADDREL  = 3,
  parameter int INITDLY = 70
) (
  input logic clk,
  input logic rst,
  freeblk_client_if.slave bus
);
  localparam int CD = 2 ** ADDCAC;
  localparam int RD = 2 ** ADDREL;
  localparam int CW = $clog2(INITDLY + 1);
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [ADDBLK-1:0] r_cache [CD];
  logic [ADDCAC-1:0] r_cwp, r_crp;
  logic [ADDCAC:0]   r_clen;
  logic [ADDBLK-1:0] r_relq [RD];
  logic [ADDREL-1:0] r_qwp, r_qrp;
  logic [ADDREL:0]   r_qlen;
  logic              r_ack, r_busy, r_miss, r_free, r_drop, r_dup;
  logic [ADDBLK-1:0] r_blkid, r_rdid;
  logic              w_flush, w_done, w_get, w_grant, w_miss, w_pop, w_push, w_drop, w_rel_ok, w_dup;
  assign w_flush = r_state == IDLE || !bus.active;
  assign w_done  = r_cnt == CW'(INITDLY - 1);
  assign w_get   = bus.wrblkrdy && r_state != IDLE && !r_clen[ADDCAC];
  assign w_grant = !w_flush && (bus.eng_req || r_busy) && r_clen != '0;
  assign w_miss  = !w_flush && bus.eng_req && !r_busy && r_clen == '0;
  assign w_pop   = r_state == RUN && bus.active && r_qlen != '0;
  // a pop frees a slot in the same cycle, so a full queue still accepts a push alongside it
  assign w_push  = !w_flush && w_rel_ok && (!r_qlen[ADDREL] || w_pop);
  assign w_drop  = !w_flush && w_rel_ok && r_qlen[ADDREL] && !w_pop;
`ifdef FREEBLK_DUPCHK_EN
  logic [2**ADDBLK-1:0] r_own;
  assign w_rel_ok = bus.rel_vld && r_own[bus.rel_id];
  assign w_dup    = !w_flush && bus.rel_vld && !r_own[bus.rel_id];
  always_ff @(posedge clk) begin
    if (rst || w_flush) r_own <= '0;
    else begin
      if (w_get) r_own[bus.wrblkid] <= 1'b1;
      if (w_push) r_own[bus.rel_id] <= 1'b0;
    end
  end
`else
  assign w_rel_ok = bus.rel_vld;
  assign w_dup    = 1'b0;
`endif
  always_comb begin
    w_next = !bus.active ? IDLE : r_state == IDLE ? INIT : (r_state == INIT && w_done) ? RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_cnt   <= '0;
      r_cwp   <= '0;
      r_crp   <= '0;
      r_clen  <= '0;
      r_qwp   <= '0;
      r_qrp   <= '0;
      r_qlen  <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_miss  <= 1'b0;
      r_free  <= 1'b0;
      r_drop  <= 1'b0;
      r_dup   <= 1'b0;
      r_blkid <= '0;
      r_rdid  <= '0;
    end else begin
      r_cnt <= w_done ? r_cnt : r_cnt + 1'b1;
      if (w_get) begin
        r_cache[r_cwp] <= bus.wrblkid;
        r_cwp          <= r_cwp + 1'b1;
      end
      if (w_grant) begin
        r_blkid <= r_cache[r_crp];
        r_crp   <= r_crp + 1'b1;
      end
      r_clen <= r_clen + (ADDCAC+1)'(w_get) - (ADDCAC+1)'(w_grant);
      r_ack  <= w_grant;
      r_miss <= w_miss;
      r_busy <= w_grant ? 1'b0 : w_miss ? 1'b1 : r_busy;
      if (w_push) begin
        r_relq[r_qwp] <= bus.rel_id;
        r_qwp         <= r_qwp + 1'b1;
      end
      if (w_pop) begin
        r_rdid <= r_relq[r_qrp];
        r_qrp  <= r_qrp + 1'b1;
      end
      r_qlen <= r_qlen + (ADDREL+1)'(w_push) - (ADDREL+1)'(w_pop);
      r_free <= w_pop;
      r_drop <= w_drop;
      r_dup  <= w_dup;
    end
  end
  assign bus.wrblkget  = w_get;
  assign bus.rdblkfree = r_free;
  assign bus.rdblkid   = r_rdid;
  assign bus.eng_ack   = r_ack;
  assign bus.eng_blkid = r_blkid;
  assign bus.eng_busy  = r_busy;
  assign bus.rel_full  = r_qlen[ADDREL];
  assign bus.cache_len = r_clen;
  assign bus.rel_drop  = r_drop;
  assign bus.eng_miss  = r_miss;
  assign bus.dup_err   = r_dup;
endmodule

// File: tb/tb_freeblk_client.sv
// tb_freeblk_client: directed table and sequence checks of freeblk_client prefetch, grant and release paths
module tb_freeblk_client;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic got = 1'b0;
  logic mgr_auto = 1'b0;
  always #5 clk = ~clk;
  freeblk_client_if #(.ADDBLK(11), .ADDCAC(2)) bus ();
  freeblk_client #(.ADDBLK(11), .ADDCAC(2), .ADDREL(3), .INITDLY(70)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  typedef struct {
    logic act, rdy, req, get;
    int clen;
    logic ack;
    logic [10:0] id;
    logic busy, miss;
  } vec_t;
  vec_t tv [21];
  function automatic vec_t mk(input int a, r, q, g, cl, k, id, b, m);
    vec_t v;
    v.act = a[0]; v.rdy = r[0]; v.req = q[0]; v.get = g[0]; v.clen = cl;
    v.ack = k[0]; v.id = id[10:0]; v.busy = b[0]; v.miss = m[0];
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    got = bus.wrblkget;
    @(posedge clk);
    #1;
    if (mgr_auto && got) bus.wrblkid = bus.wrblkid + 1'b1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.active = 1'b0; bus.wrblkrdy = 1'b0; bus.wrblkid = '0;
    bus.eng_req = 1'b0; bus.rel_vld = 1'b0; bus.rel_id = '0;
    mgr_auto = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
  endtask
  initial begin
    int frees, drops, dups, first, last;
    logic [10:0] ids [$];
    tv[0]  = mk(1,1,0, 0,0,0,0,0,0);
    tv[1]  = mk(1,1,0, 1,1,0,0,0,0);
    tv[2]  = mk(1,1,0, 1,2,0,0,0,0);
    tv[3]  = mk(1,1,0, 1,3,0,0,0,0);
    tv[4]  = mk(1,1,0, 1,4,0,0,0,0);
    tv[5]  = mk(1,1,0, 0,4,0,0,0,0);
    tv[6]  = mk(1,1,1, 0,3,1,'h010,0,0);
    tv[7]  = mk(1,1,0, 1,4,0,0,0,0);
    tv[8]  = mk(1,0,1, 0,3,1,'h011,0,0);
    tv[9]  = mk(1,0,0, 0,3,0,0,0,0);
    tv[10] = mk(1,0,1, 0,2,1,'h012,0,0);
    tv[11] = mk(1,0,0, 0,2,0,0,0,0);
    tv[12] = mk(1,0,1, 0,1,1,'h013,0,0);
    tv[13] = mk(1,0,0, 0,1,0,0,0,0);
    tv[14] = mk(1,0,1, 0,0,1,'h014,0,0);
    tv[15] = mk(1,0,0, 0,0,0,0,0,0);
    tv[16] = mk(1,0,1, 0,0,0,0,1,1);
    tv[17] = mk(1,0,1, 0,0,0,0,1,0);
    tv[18] = mk(1,1,0, 1,1,0,0,1,0);
    tv[19] = mk(1,0,0, 0,0,1,'h015,0,0);
    tv[20] = mk(1,0,0, 0,0,0,0,0,0);
    do_reset();
    chk("reset_flags", {got, bus.eng_ack, bus.rdblkfree, bus.rel_full, bus.eng_busy,
                        bus.eng_miss, bus.rel_drop, bus.dup_err}, 0);
    chk("reset_cache_len", bus.cache_len, 0);
    bus.wrblkid = 11'h010;
    mgr_auto = 1'b1;
    for (int i = 0; i < 21; i++) begin
      bus.active = tv[i].act; bus.wrblkrdy = tv[i].rdy; bus.eng_req = tv[i].req;
      cyc();
      chk($sformatf("v%0d_wrblkget", i), got, tv[i].get);
      chk($sformatf("v%0d_cache_len", i), bus.cache_len, tv[i].clen);
      chk($sformatf("v%0d_eng_ack", i), bus.eng_ack, tv[i].ack);
      if (tv[i].ack) chk($sformatf("v%0d_eng_blkid", i), bus.eng_blkid, tv[i].id);
      chk($sformatf("v%0d_eng_busy", i), bus.eng_busy, tv[i].busy);
      chk($sformatf("v%0d_eng_miss", i), bus.eng_miss, tv[i].miss);
    end
    do_reset();
    bus.active = 1'b1;
    frees = 0; first = -1; ids.delete();
    for (int c = 0; c < 100; c++) begin
      bus.rel_vld = c == 5; bus.rel_id = 11'h005;
      cyc();
      if (bus.rdblkfree) begin
        frees++;
        if (first < 0) first = c + 1;
        ids.push_back(bus.rdblkid);
      end
    end
    chk("init_first_free_cycle", first, 72);
    chk("init_free_count", frees, 1);
    if (ids.size() > 0) chk("init_free_id", ids[0], 11'h005);
    do_reset();
    bus.active = 1'b1;
    drops = 0; ids.delete();
    for (int c = 0; c < 100; c++) begin
      bus.rel_vld = c >= 2 && c <= 10; bus.rel_id = 11'(256 + c - 2);
      cyc();
      if (c + 1 == 9) chk("rel_full_after7", bus.rel_full, 0);
      if (c + 1 == 10) chk("rel_full_after8", bus.rel_full, 1);
      if (c + 1 == 11) chk("rel_drop_pulse", bus.rel_drop, 1);
      drops += int'(bus.rel_drop);
      if (bus.rdblkfree) ids.push_back(bus.rdblkid);
    end
    chk("rel_drop_count", drops, 1);
    chk("rel_free_count", ids.size(), 8);
    for (int k = 0; k < ids.size() && k < 8; k++) chk($sformatf("rel_order%0d", k), ids[k], 11'(256 + k));
    chk("rel_full_drained", bus.rel_full, 0);
    do_reset();
    frees = 0; last = -1;
    for (int c = 0; c < 200; c++) begin
      bus.active = !(c >= 73 && c < 95);
      bus.rel_vld = c >= 2 && c <= 5; bus.rel_id = 11'(512 + c);
      cyc();
      if (bus.rdblkfree) begin
        frees++;
        last = c + 1;
      end
      if (c + 1 == 80) chk("flush_cache_len", bus.cache_len, 0);
    end
    chk("flush_free_count", frees, 2);
    chk("flush_last_free_cycle", last, 73);
    do_reset();
    bus.active = 1'b1;
    repeat (75) cyc();
    bus.wrblkid = 11'h033; bus.wrblkrdy = 1'b1;
    cyc();
    chk("dup_take_get", got, 1);
    bus.wrblkrdy = 1'b0;
    frees = 0; dups = 0; ids.delete();
    for (int c = 0; c < 20; c++) begin
      bus.rel_vld = c < 2; bus.rel_id = 11'h033;
      cyc();
      dups += int'(bus.dup_err);
      if (bus.rdblkfree) begin
        frees++;
        ids.push_back(bus.rdblkid);
      end
    end
    bus.rel_vld = 1'b0;
`ifdef FREEBLK_DUPCHK_EN
    chk("dup_free_count", frees, 1);
    chk("dup_err_count", dups, 1);
`else
    chk("nodup_free_count", frees, 2);
    chk("nodup_err_count", dups, 0);
`endif
    if (ids.size() > 0) chk("dup_free_id", ids[0], 11'h033);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
